// File: rtl/booth_encoder.sv
// Radix-4 Booth partial-product generator: decodes one 3-bit multiplier window
// and registers the selected signed multiple of M, sign-extended to 2*WIDTH bits.
module booth_encoder #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [2:0]         bits,
    input  logic [WIDTH-1:0]   M,
    output logic [2*WIDTH-1:0] current_M,
    output logic               out_valid,
    output logic               neg,
    output logic               two,
    output logic               zero
);

    logic [2*WIDTH-1:0] m_ext;
    logic [2*WIDTH-1:0] magnitude;
    logic [2*WIDTH-1:0] selected;
    logic               sel_zero;
    logic               sel_two;
    logic               sel_neg;

    // 111 selects zero, so it must not raise neg (no negative zero).
    always_comb begin
        sel_zero = (bits == 3'b000) || (bits == 3'b111);
        sel_two  = (bits == 3'b011) || (bits == 3'b100);
        sel_neg  = bits[2] && (bits != 3'b111);
    end

    // Working in 2*WIDTH bits means -2*(-2^(WIDTH-1)) cannot overflow.
    always_comb begin
        m_ext     = {{WIDTH{M[WIDTH-1]}}, M};
        magnitude = sel_two ? (m_ext << 1) : m_ext;
        selected  = '0;
        if (!sel_zero) begin
            selected = sel_neg ? -magnitude : magnitude;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            current_M <= '0;
            out_valid <= 1'b0;
            neg       <= 1'b0;
            two       <= 1'b0;
            zero      <= 1'b1;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                current_M <= selected;
                neg       <= sel_neg;
                two       <= sel_two;
                zero      <= sel_zero;
            end
        end
    end

endmodule

// File: tb/tb_booth_encoder.sv
// Self-checking bench for booth_encoder: directed vector table, reset corner
// cases, randomized windows against a coefficient model, and full multiplies.
module tb_booth_encoder;

    localparam int WIDTH = 32;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic [2:0]         bits;
    logic [WIDTH-1:0]   M;
    logic [2*WIDTH-1:0] current_M;
    logic               out_valid;
    logic               neg;
    logic               two;
    logic               zero;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        valid;
        logic [2:0]  bits;
        logic [31:0] m;
        logic [63:0] cm;
        logic        ov;
        logic        neg;
        logic        two;
        logic        zero;
    } vec_t;

    vec_t vecs[$];

    booth_encoder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .bits      (bits),
        .M         (M),
        .current_M (current_M),
        .out_valid (out_valid),
        .neg       (neg),
        .two       (two),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic v, input logic [2:0] b, input logic [31:0] m,
                                input logic [63:0] cm, input logic ov, input logic n,
                                input logic t, input logic z);
        vec_t r;
        r.valid = v; r.bits = b; r.m = m; r.cm = cm;
        r.ov = ov; r.neg = n; r.two = t; r.zero = z;
        return r;
    endfunction

    // Booth digit value of a window: -2*b2 + b1 + b0.
    function automatic int coeff(input logic [2:0] b);
        return int'(b[1]) + int'(b[0]) - 2 * int'(b[2]);
    endfunction

    // Drive inputs just after an edge, then let the next edge capture them.
    task automatic applyStimulus(input logic v, input logic [2:0] b, input logic [31:0] m);
        in_valid = v;
        bits     = b;
        M        = m;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] ecm, input logic eov,
                               input logic en, input logic et, input logic ez);
        checks++;
        if ({current_M, out_valid, neg, two, zero} !== {ecm, eov, en, et, ez}) begin
            errors++;
            $display("[TB] FAIL %s: got cm=%h ov=%b neg=%b two=%b zero=%b, want cm=%h ov=%b neg=%b two=%b zero=%b",
                     name, current_M, out_valid, neg, two, zero, ecm, eov, en, et, ez);
        end
    endtask

    // Feed all 16 windows of q, shift-accumulate the results and compare with q*m.
    task automatic doMultiply(input string name, input logic [31:0] q, input logic [31:0] m,
                              input logic [63:0] expected);
        logic [32:0] qext;
        logic [63:0] sum;
        qext = {q, 1'b0};
        sum  = '0;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, qext[2*i+2 -: 3], m);
            sum = sum + (current_M << (2 * i));
        end
        checks++;
        if (sum !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got product=%h, want %h", name, sum, expected);
        end
    endtask

    initial begin
        logic [63:0] exp_cm;
        logic        exp_ov, exp_neg, exp_two, exp_zero;
        logic        v;
        logic [2:0]  b;
        logic [31:0] m;
        logic [31:0] q;
        int          c;

        rst = 1'b1; in_valid = 1'b1; bits = 3'b011; M = 32'd5;

        // Reset holds even with a valid window on the inputs.
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_hold", 64'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("reset_release", 64'h000000000000000A, 1'b1, 1'b0, 1'b1, 1'b0);

        vecs.push_back(mk(1, 3'b000, 32'd5,        64'h0,                1, 0, 0, 1));
        vecs.push_back(mk(1, 3'b001, 32'd5,        64'h5,                1, 0, 0, 0));
        vecs.push_back(mk(1, 3'b010, 32'd5,        64'h5,                1, 0, 0, 0));
        vecs.push_back(mk(1, 3'b011, 32'd5,        64'hA,                1, 0, 1, 0));
        vecs.push_back(mk(1, 3'b100, 32'd5,        64'hFFFFFFFFFFFFFFF6, 1, 1, 1, 0));
        vecs.push_back(mk(1, 3'b101, 32'd5,        64'hFFFFFFFFFFFFFFFB, 1, 1, 0, 0));
        vecs.push_back(mk(1, 3'b110, 32'd5,        64'hFFFFFFFFFFFFFFFB, 1, 1, 0, 0));
        vecs.push_back(mk(1, 3'b111, 32'd5,        64'h0,                1, 0, 0, 1));
        vecs.push_back(mk(1, 3'b001, 32'h80000000, 64'hFFFFFFFF80000000, 1, 0, 0, 0));
        vecs.push_back(mk(1, 3'b011, 32'h80000000, 64'hFFFFFFFF00000000, 1, 0, 1, 0));
        vecs.push_back(mk(1, 3'b100, 32'h80000000, 64'h0000000100000000, 1, 1, 1, 0));
        vecs.push_back(mk(1, 3'b101, 32'h80000000, 64'h0000000080000000, 1, 1, 0, 0));
        vecs.push_back(mk(1, 3'b010, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1, 0, 0, 0));
        vecs.push_back(mk(1, 3'b110, 32'hFFFFFFFF, 64'h1,                1, 1, 0, 0));
        vecs.push_back(mk(1, 3'b011, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFE, 1, 0, 1, 0));
        vecs.push_back(mk(1, 3'b001, 32'd0,        64'h0,                1, 0, 0, 0));
        vecs.push_back(mk(1, 3'b001, 32'd3,        64'h3,                1, 0, 0, 0));
        vecs.push_back(mk(0, 3'b011, 32'd3,        64'h3,                0, 0, 0, 0));
        vecs.push_back(mk(1, 3'b100, 32'd3,        64'hFFFFFFFFFFFFFFFA, 1, 1, 1, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].valid, vecs[i].bits, vecs[i].m);
            checkOutput($sformatf("vec%0d", i), vecs[i].cm, vecs[i].ov,
                        vecs[i].neg, vecs[i].two, vecs[i].zero);
        end

        // Asynchronous reset mid-stream must clear before the next edge.
        applyStimulus(1'b1, 3'b011, 32'd7);
        checkOutput("pre_async_reset", 64'hE, 1'b1, 1'b0, 1'b1, 1'b0);
        #2 rst = 1'b1;
        #1;
        checkOutput("async_reset_immediate", 64'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        checkOutput("async_reset_held", 64'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        in_valid = 1'b0;
        rst = 1'b0;

        exp_cm = '0; exp_ov = 1'b0; exp_neg = 1'b0; exp_two = 1'b0; exp_zero = 1'b1;
        for (int i = 0; i < 300; i++) begin
            v = ($urandom_range(0, 4) != 0);
            b = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 5))
                0:       m = 32'h80000000;
                1:       m = 32'h7FFFFFFF;
                2:       m = 32'hFFFFFFFF;
                3:       m = 32'h0;
                default: m = $urandom;
            endcase
            applyStimulus(v, b, m);
            exp_ov = v;
            if (v) begin
                c        = coeff(b);
                exp_cm   = 64'(longint'($signed(m)) * longint'(c));
                exp_neg  = (c < 0);
                exp_two  = (c == 2) || (c == -2);
                exp_zero = (c == 0);
            end
            checkOutput($sformatf("rand%0d", i), exp_cm, exp_ov, exp_neg, exp_two, exp_zero);
        end

        doMultiply("mult_7x-9", 32'd7, 32'hFFFFFFF7, 64'hFFFFFFFFFFFFFFC1);
        for (int i = 0; i < 8; i++) begin
            q = $urandom;
            m = $urandom;
            doMultiply($sformatf("mult_rand%0d", i), q, m,
                       64'(longint'($signed(q)) * longint'($signed(m))));
        end
        doMultiply("mult_minxmin", 32'h80000000, 32'h80000000, 64'h4000000000000000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
